// File: rtl/frame_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : frame_cfg_pkg
// Brief    : Shared constants, header field offsets and FSM state encoding
//            for the frame configuration writer.
// Revision : 1.0  initial release
// ============================================================================
package frame_cfg_pkg;

    localparam logic [31:0] SYNC_WORD     = 32'hFAB0_FAB1;
    localparam logic [7:0]  DESYNC_OP     = 8'hDE;

    localparam int          HDR_OP_LSB    = 24;
    localparam int          HDR_OP_W      = 8;
    localparam int          HDR_COL_LSB   = 16;
    localparam int          HDR_COL_W     = 8;
    localparam int          HDR_FRAME_LSB = 0;
    localparam int          HDR_FRAME_W   = 5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } state_t;

endpackage : frame_cfg_pkg
`default_nettype wire

// File: rtl/frame_strobe_decoder.sv
`default_nettype none
// ============================================================================
// Module   : frame_strobe_decoder
// Brief    : Combinational (column, frame, enable) to one-hot strobe decode.
// Revision : 1.0  initial release
// ============================================================================
module frame_strobe_decoder
    import frame_cfg_pkg::*;
#(
    parameter int MAX_FRAMES = 20,
    parameter int NUM_COLS   = 8,
    parameter int COL_W      = 3,
    parameter int FRAME_W    = 5
) (
    input  logic [COL_W-1:0]             i_column,
    input  logic [FRAME_W-1:0]           i_frame,
    input  logic                         i_en,
    output logic [MAX_FRAMES*NUM_COLS-1:0] o_strobe
);

    always_comb begin
        o_strobe = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int f = 0; f < MAX_FRAMES; f++) begin
                if (i_en && (i_column == COL_W'(c)) && (i_frame == FRAME_W'(f)))
                    o_strobe[c*MAX_FRAMES+f] = 1'b1;
            end
        end
    end

endmodule : frame_strobe_decoder
`default_nettype wire

// File: rtl/frame_config_writer.sv
`default_nettype none
// ============================================================================
// Module   : frame_config_writer
// Brief    : Bitstream word consumer that assembles a frame column-slice and
//            pulses the matching FrameStrobe bit for the fabric tiles.
// Revision : 1.0  initial release
// ============================================================================
module frame_config_writer
    import frame_cfg_pkg::*;
#(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumRows         = 16,
    parameter int NumColumns      = 8
) (
    input  logic                                  UserCLK,
    input  logic                                  rst,
    input  logic [31:0]                           s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [FrameBitsPerRow*NumRows-1:0]    FrameData,
    output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe,
    output logic                                  busy,
    output logic                                  err,
    output logic [15:0]                           frame_count
);

    localparam int COL_W   = $clog2(NumColumns);
    localparam int FRAME_W = $clog2(MaxFramesPerCol);
    localparam int ROW_W   = $clog2(NumRows);

    state_t                                r_state;
    logic                                  r_ready;
    logic [FrameBitsPerRow*NumRows-1:0]    r_data;
    logic [MaxFramesPerCol*NumColumns-1:0] r_strobe;
    logic                                  r_err;
    logic [15:0]                           r_frame_count;
    logic [ROW_W-1:0]                      r_row_cnt;
    logic [COL_W-1:0]                      r_column;
    logic [FRAME_W-1:0]                    r_frame;

    logic                                  w_accept;
    logic                                  w_last;
    logic [HDR_OP_W-1:0]                   w_hdr_op;
    logic [HDR_COL_W-1:0]                  w_hdr_col;
    logic [HDR_FRAME_W-1:0]                w_hdr_frame;
    logic                                  w_hdr_ok;
    logic [MaxFramesPerCol*NumColumns-1:0] w_strobe;

    assign w_accept    = s_valid && r_ready;
    assign w_hdr_op    = s_data[HDR_OP_LSB    +: HDR_OP_W];
    assign w_hdr_col   = s_data[HDR_COL_LSB   +: HDR_COL_W];
    assign w_hdr_frame = s_data[HDR_FRAME_LSB +: HDR_FRAME_W];
    assign w_hdr_ok    = (w_hdr_col < HDR_COL_W'(NumColumns)) &&
                         (w_hdr_frame < HDR_FRAME_W'(MaxFramesPerCol));
    assign w_last      = (r_state == DATA) && w_accept &&
                         (r_row_cnt == ROW_W'(NumRows - 1));

    // Decode is enabled only on the final data word so the registered strobe
    // lands exactly in the STROBE cycle and is zero everywhere else.
    frame_strobe_decoder #(
        .MAX_FRAMES (MaxFramesPerCol),
        .NUM_COLS   (NumColumns),
        .COL_W      (COL_W),
        .FRAME_W    (FRAME_W)
    ) u_decoder (
        .i_column   (r_column),
        .i_frame    (r_frame),
        .i_en       (w_last),
        .o_strobe   (w_strobe)
    );

    always_ff @(posedge UserCLK) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_ready       <= 1'b0;
            r_data        <= '0;
            r_strobe      <= '0;
            r_err         <= 1'b0;
            r_frame_count <= 16'd0;
            r_row_cnt     <= '0;
            r_column      <= '0;
            r_frame       <= '0;
        end else begin
            r_strobe <= w_strobe;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept && (s_data == SYNC_WORD))
                        r_state <= ADDR;
                end
                ADDR: begin
                    r_ready <= 1'b1;
                    if (w_accept && (s_data != SYNC_WORD)) begin
                        if (w_hdr_op == DESYNC_OP) begin
                            r_state <= IDLE;
                        end else if (!w_hdr_ok) begin
                            r_err   <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_column  <= w_hdr_col[COL_W-1:0];
                            r_frame   <= w_hdr_frame[FRAME_W-1:0];
                            r_row_cnt <= '0;
                            r_state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_data[r_row_cnt*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                        r_row_cnt <= r_row_cnt + 1'b1;
                        if (w_last) begin
                            r_ready <= 1'b0;
                            r_state <= STROBE;
                        end
                    end
                end
                STROBE: begin
                    r_ready       <= 1'b0;
                    r_frame_count <= r_frame_count + 16'd1;
                    r_state       <= HOLD;
                end
                HOLD: begin
                    r_ready <= 1'b1;
                    r_state <= ADDR;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s_ready     = r_ready;
    assign FrameData   = r_data;
    assign FrameStrobe = r_strobe;
    assign busy        = (r_state != IDLE);
    assign err         = r_err;
    assign frame_count = r_frame_count;

endmodule : frame_config_writer
`default_nettype wire

// File: tb/tb_frame_config_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_config_writer
// Brief    : Directed self-checking bench for frame_config_writer.
// Revision : 1.0  initial release
// ============================================================================
module tb_frame_config_writer;

    localparam logic [31:0] C_SYNC = 32'hFAB0_FAB1;

    logic         UserCLK = 1'b0;
    logic         rst     = 1'b0;
    logic [31:0]  s_data  = '0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [511:0] FrameData;
    logic [159:0] FrameStrobe;
    logic         busy;
    logic         err;
    logic [15:0]  frame_count;

    int n_vec = 0;
    int n_err = 0;
    int strobe_cnt = 0;
    int bad_strobe = 0;
    int nrdy_cnt = 0;
    bit nrdy_win = 1'b0;
    bit hold_chk = 1'b0;
    logic [511:0] fd_cap;
    logic [511:0] fd_exp;
    logic [159:0] st_exp;

    frame_config_writer dut (
        .UserCLK     (UserCLK),
        .rst         (rst),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .err         (err),
        .frame_count (frame_count)
    );

    always #5 UserCLK = ~UserCLK;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: one-hot-or-zero, only while busy, data held into HOLD.
    always @(negedge UserCLK) begin
        if ($countones(FrameStrobe) > 1) bad_strobe++;
        if ((FrameStrobe != '0) && !busy) bad_strobe++;
        if (nrdy_win && !s_ready) nrdy_cnt++;
        if (hold_chk) begin
            chk("fd_hold", FrameData, fd_cap);
            hold_chk = 1'b0;
        end
        if (FrameStrobe != '0) begin
            strobe_cnt++;
            fd_cap   = FrameData;
            hold_chk = 1'b1;
        end
    end

    task automatic send(input logic [31:0] d, input int gap);
        bit ok;
        s_valid = 1'b0;
        repeat (gap) @(negedge UserCLK);
        s_valid = 1'b1;
        s_data  = d;
        for (int t = 0; t < 64; t++) begin
            ok = s_ready;
            @(negedge UserCLK);
            if (ok) begin
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        chk("send_timeout", 1'b1, 1'b0);
    endtask

    task automatic run_frame(input logic [31:0] hdr, input logic [31:0] base, input int maxgap);
        send(hdr, $urandom_range(0, maxgap));
        for (int k = 0; k < 16; k++) begin
            send(base + k, $urandom_range(0, maxgap));
            fd_exp[k*32 +: 32] = base + k;
        end
    endtask

    initial begin
        fd_exp = '0;
        repeat (3) @(negedge UserCLK);
        chk("rst_ready",  s_ready,     1'b0);
        chk("rst_data",   FrameData,   512'd0);
        chk("rst_strobe", FrameStrobe, 160'd0);
        chk("rst_busy",   busy,        1'b0);
        chk("rst_err",    err,         1'b0);
        chk("rst_count",  frame_count, 16'd0);
        rst = 1'b1;

        // Basic frame: column 3, frame 7 -> strobe bit 67
        send(C_SYNC, 0);
        run_frame(32'h0003_0007, 32'h1000_0000, 0);
        st_exp = '0; st_exp[67] = 1'b1;
        chk("t2_strobe", FrameStrobe, st_exp);
        chk("t2_data",   FrameData,   fd_exp);
        @(negedge UserCLK);
        chk("t2_strobe_off", FrameStrobe, 160'd0);
        chk("t2_ready_hold", s_ready,     1'b0);
        chk("t2_count",      frame_count, 16'd1);

        // Column out of range: sticky err, words discarded until SYNC
        send(32'h0008_0001, 0);
        chk("t3_err",  err,  1'b1);
        chk("t3_busy", busy, 1'b0);
        for (int k = 0; k < 16; k++) send(32'h3000_0000 + k, 0);
        repeat (2) @(negedge UserCLK);
        chk("t3_no_strobe", strobe_cnt, 1);
        chk("t3_still_idle", busy, 1'b0);

        // Reset in the middle of DATA
        send(C_SYNC, 0);
        send(32'h0002_0003, 0);
        for (int k = 0; k < 5; k++) send(32'h4000_0000 + k, 0);
        chk("t1_busy_pre", busy, 1'b1);
        rst = 1'b0;
        @(negedge UserCLK);
        chk("t1_ready_in_rst", s_ready, 1'b0);
        @(negedge UserCLK);
        rst = 1'b1;
        chk("t1_data",   FrameData,   512'd0);
        chk("t1_strobe", FrameStrobe, 160'd0);
        chk("t1_busy",   busy,        1'b0);
        chk("t1_err",    err,         1'b0);
        chk("t1_count",  frame_count, 16'd0);
        chk("t1_no_partial", strobe_cnt, 1);

        // Three back-to-back frames with random valid gaps; corner strobe bits
        send(C_SYNC, 0);
        send(C_SYNC, 1);
        nrdy_win = 1'b1;
        run_frame(32'h0000_0000, 32'hA000_0000, 1);
        st_exp = '0; st_exp[0] = 1'b1;
        chk("t4_strobe0", FrameStrobe, st_exp);
        chk("t4_data0",   FrameData,   fd_exp);
        run_frame(32'h0007_0013, 32'hA100_0100, 1);
        st_exp = '0; st_exp[159] = 1'b1;
        chk("t4_strobe1", FrameStrobe, st_exp);
        chk("t4_data1",   FrameData,   fd_exp);
        run_frame(32'h0005_000C, 32'hA200_0200, 1);
        st_exp = '0; st_exp[112] = 1'b1;
        chk("t4_strobe2", FrameStrobe, st_exp);
        chk("t4_data2",   FrameData,   fd_exp);
        repeat (3) @(negedge UserCLK);
        nrdy_win = 1'b0;
        chk("t4_notready_cycles", nrdy_cnt, 6);
        chk("t4_strobes", strobe_cnt, 4);
        chk("t4_count",   frame_count, 16'd3);

        // Desync returns to IDLE; a header without SYNC is ignored
        send(C_SYNC, 0);
        send(32'hDE00_0000, 0);
        chk("t5_busy", busy, 1'b0);
        send(32'h0001_0002, 0);
        for (int k = 0; k < 16; k++) send(32'h2000_0000 + k, 0);
        repeat (2) @(negedge UserCLK);
        chk("t5_no_strobe", strobe_cnt, 4);
        chk("t5_idle", busy, 1'b0);

        // Frame counter wrap
        force dut.r_frame_count = 16'hFFFF;
        @(negedge UserCLK);
        release dut.r_frame_count;
        @(negedge UserCLK);
        chk("t6_preset", frame_count, 16'hFFFF);
        send(C_SYNC, 0);
        run_frame(32'h0004_0009, 32'h5000_0000, 0);
        st_exp = '0; st_exp[89] = 1'b1;
        chk("t6_strobe", FrameStrobe, st_exp);
        @(negedge UserCLK);
        chk("t6_wrap", frame_count, 16'd0);

        repeat (2) @(negedge UserCLK);
        chk("total_strobes", strobe_cnt, 5);
        chk("strobe_onehot_in_busy", bad_strobe, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule : tb_frame_config_writer
`default_nettype wire
